hls_run_sequencer: RTL

//  Synthesizable run controller for a Bambu-generated top (start_port/done_port handshake).

---
 rtl/hls_run_sequencer_if.sv | 34 +++
 rtl/hls_run_sequencer.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/hls_run_sequencer_if.sv
// Control and result bundle shared by host/bench, run sequencer and the HLS top handshake.
// master = sequencer side, slave = host side (which also models the HLS top's done_port).
interface hls_run_sequencer_if #(
    parameter int CNT_W = 32,
    parameter int RUN_W = 8
);
    logic                   go;
    logic [RUN_W-1:0]       num_runs;
    logic                   dut_reset_n;
    logic                   dut_start;
    logic                   dut_done;
    logic                   res_valid;
    logic [RUN_W-1:0]       res_index;
    logic [CNT_W-1:0]       res_cycles;
    logic                   res_timeout;
    logic                   busy;
    logic                   finished;
    logic                   error;
    logic [CNT_W-1:0]       min_cycles;
    logic [CNT_W-1:0]       max_cycles;
    logic [CNT_W+RUN_W-1:0] sum_cycles;

    modport master (
        input  go, num_runs, dut_done,
        output dut_reset_n, dut_start, res_valid, res_index, res_cycles, res_timeout,
               busy, finished, error, min_cycles, max_cycles, sum_cycles
    );

    modport slave (
        output go, num_runs, dut_done,
        input  dut_reset_n, dut_start, res_valid, res_index, res_cycles, res_timeout,
               busy, finished, error, min_cycles, max_cycles, sum_cycles
    );
endinterface

// File: rtl/hls_run_sequencer.sv
// Multi-run controller for a start/done HLS top with watchdog; HLS_RUN_SEQ_STATS_EN builds min/max/sum stats.
// Latency: all outputs registered, one cycle after the state decision; result strobe in the REPORT/TMO cycle.
// Backpressure: none; go is only accepted in IDLE, results are fire-and-forget strobes.
module hls_run_sequencer #(
    parameter int CNT_W          = 32,
    parameter int RUN_W          = 8,
    parameter int RST_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 200000000
) (
    input  logic                clock,
    input  logic                reset,
    hls_run_sequencer_if.master bus
);
    localparam int RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [RC_W-1:0]  RST_LAST = RC_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LIM  = CNT_W'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE, S_RST, S_START, S_RUN, S_REPORT, S_TMO, S_FIN
    } state_t;

    state_t             state_q, state_d;
    logic [RC_W-1:0]    rst_cnt_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [RUN_W-1:0]   num_q, idx_q, idx_nxt;
    logic               go_acc, done_now, at_limit, last_run;

    logic               dut_reset_n_q, dut_start_q, res_valid_q, busy_q;
    logic               dut_reset_n_d, dut_start_d, res_valid_d, busy_d;
    logic [RUN_W-1:0]   res_index_q;
    logic [CNT_W-1:0]   res_cycles_q;
    logic               res_timeout_q, finished_q, error_q;

    assign go_acc   = (state_q == S_IDLE) && bus.go;
    assign done_now = bus.dut_done && ((state_q == S_START) || (state_q == S_RUN));
    assign at_limit = (cnt_q == TMO_LIM);
    assign idx_nxt  = idx_q + RUN_W'(1);
    assign last_run = (idx_nxt == num_q);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (bus.go) state_d = (bus.num_runs == '0) ? S_FIN : S_RST;
            S_RST:    if (rst_cnt_q == RST_LAST) state_d = S_START;
            S_START,
            S_RUN: begin
                // A done arriving on the watchdog limit cycle still counts as a completed run.
                if (done_now)      state_d = S_REPORT;
                else if (at_limit) state_d = S_TMO;
                else               state_d = S_RUN;
            end
            S_REPORT: state_d = last_run ? S_FIN : S_RST;
            S_TMO:    state_d = S_FIN;
            S_FIN:    state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        dut_reset_n_d = 1'b1;
        dut_start_d   = 1'b0;
        res_valid_d   = 1'b0;
        busy_d        = 1'b0;
        case (state_d)
            S_RST:    begin dut_reset_n_d = 1'b0; busy_d = 1'b1; end
            S_START:  begin dut_start_d   = 1'b1; busy_d = 1'b1; end
            S_RUN:    busy_d = 1'b1;
            S_REPORT,
            S_TMO:    begin res_valid_d   = 1'b1; busy_d = 1'b1; end
            default:  ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rst_cnt_q     <= '0;
            cnt_q         <= '0;
            num_q         <= '0;
            idx_q         <= '0;
            dut_reset_n_q <= 1'b0;
            dut_start_q   <= 1'b0;
            res_valid_q   <= 1'b0;
            busy_q        <= 1'b0;
            res_index_q   <= '0;
            res_cycles_q  <= '0;
            res_timeout_q <= 1'b0;
            finished_q    <= 1'b0;
            error_q       <= 1'b0;
        end else begin
            dut_reset_n_q <= dut_reset_n_d;
            dut_start_q   <= dut_start_d;
            res_valid_q   <= res_valid_d;
            busy_q        <= busy_d;

            rst_cnt_q <= (state_q == S_RST) ? rst_cnt_q + RC_W'(1) : '0;

            if (state_d == S_START)    cnt_q <= CNT_W'(1);
            else if (state_d == S_RUN) cnt_q <= cnt_q + CNT_W'(1);

            if (go_acc) begin
                num_q <= bus.num_runs;
                idx_q <= '0;
            end else if (state_q == S_REPORT) begin
                idx_q <= idx_nxt;
            end

            if (state_d == S_REPORT) begin
                res_index_q   <= idx_q;
                res_cycles_q  <= cnt_q;
                res_timeout_q <= 1'b0;
            end else if (state_d == S_TMO) begin
                res_index_q   <= idx_q;
                res_cycles_q  <= TMO_LIM;
                res_timeout_q <= 1'b1;
            end

            if (state_d == S_FIN) finished_q <= 1'b1;
            else if (go_acc)      finished_q <= 1'b0;

            if (state_d == S_TMO) error_q <= 1'b1;
            else if (go_acc)      error_q <= 1'b0;
        end
    end

    assign bus.dut_reset_n = dut_reset_n_q;
    assign bus.dut_start   = dut_start_q;
    assign bus.res_valid   = res_valid_q;
    assign bus.res_index   = res_index_q;
    assign bus.res_cycles  = res_cycles_q;
    assign bus.res_timeout = res_timeout_q;
    assign bus.busy        = busy_q;
    assign bus.finished    = finished_q;
    assign bus.error       = error_q;

`ifdef HLS_RUN_SEQ_STATS_EN
    logic [CNT_W-1:0]       min_q, max_q;
    logic [CNT_W+RUN_W-1:0] sum_q;

    // Only REPORT carries a real latency; watchdog aborts never reach here.
    always_ff @(posedge clock) begin
        if (reset) begin
            min_q <= '1;
            max_q <= '0;
            sum_q <= '0;
        end else if (go_acc) begin
            min_q <= '1;
            max_q <= '0;
            sum_q <= '0;
        end else if (state_d == S_REPORT) begin
            if (cnt_q < min_q) min_q <= cnt_q;
            if (cnt_q > max_q) max_q <= cnt_q;
            sum_q <= sum_q + {{RUN_W{1'b0}}, cnt_q};
        end
    end

    assign bus.min_cycles = min_q;
    assign bus.max_cycles = max_q;
    assign bus.sum_cycles = sum_q;
`else
    assign bus.min_cycles = '0;
    assign bus.max_cycles = '0;
    assign bus.sum_cycles = '0;
`endif
endmodule
